// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter.
// The receive side uses the same defaults, so both ends run at the same baud.
package uart_pkg;

    localparam int unsigned NBITS             = 8;
    localparam int unsigned TICKS_PER_BIT_DEF = 16;
    localparam int unsigned CLKS_PER_TICK_DEF = 326;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        STARTBIT = 2'b01,
        DATA     = 2'b10,
        STOPBIT  = 2'b11
    } uart_state_e;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with a show-ahead head. full and empty are registered from the next-state count.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk50,
    input  logic             nreset,
    input  logic             wr_en,
    input  logic [NBITS-1:0] wr_data,
    input  logic             rd_en,
    output logic [NBITS-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = clog2_min1(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [NBITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt_c;
    logic             wr_ok_c;
    logic             rd_ok_c;

    assign wr_ok_c = wr_en && !full;
    assign rd_ok_c = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // A write and a pop in the same cycle leave the count unchanged.
    always_comb begin
        count_nxt_c = count;
        if (wr_ok_c && !rd_ok_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (!wr_ok_c && rd_ok_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok_c) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt_c;
            full  <= (count_nxt_c == CNT_W'(FIFO_DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

    // Storage needs no reset; the pointers define which slots are valid.
    always_ff @(posedge clk50) begin
        if (wr_ok_c) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO, LSB first.
// Bit timing comes from a free-running divider used as a clock enable.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = CLKS_PER_TICK_DEF,
    parameter int unsigned TICKS_PER_BIT = TICKS_PER_BIT_DEF,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic             clk50,
    input  logic             nreset,
    input  logic             wr_en,
    input  logic [NBITS-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic             Tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV_W  = clog2_min1(CLKS_PER_TICK);
    localparam int unsigned TICK_W = clog2_min1(TICKS_PER_BIT);
    localparam int unsigned BIT_W  = clog2_min1(NBITS);

    logic [DIV_W-1:0]  div_cnt;
    logic [TICK_W-1:0] count_tick;
    logic [BIT_W-1:0]  count_bit;
    logic [NBITS-1:0]  shift;
    logic [NBITS-1:0]  head_c;
    uart_state_e       state;
    logic              tick_c;
    logic              bit_last_c;
    logic              pop_c;

    assign tick_c     = (div_cnt == DIV_W'(CLKS_PER_TICK - 1));
    assign bit_last_c = (count_tick == TICK_W'(TICKS_PER_BIT - 1));
    // Pop when a frame starts from idle or chains straight off a finishing stop bit.
    assign pop_c      = tick_c && !empty &&
                        ((state == IDLE) || ((state == STOPBIT) && bit_last_c));

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk50  (clk50),
        .nreset (nreset),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (pop_c),
        .rd_data(head_c),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            count_tick <= '0;
            count_bit  <= '0;
            shift      <= '0;
            Tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tick_c) begin
                case (state)
                    IDLE: begin
                        if (!empty) begin
                            shift      <= head_c;
                            Tx         <= 1'b0;
                            count_tick <= '0;
                            busy       <= 1'b1;
                            state      <= STARTBIT;
                        end
                    end
                    STARTBIT: begin
                        if (bit_last_c) begin
                            Tx         <= shift[0];
                            count_tick <= '0;
                            count_bit  <= '0;
                            state      <= DATA;
                        end else begin
                            count_tick <= count_tick + TICK_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_last_c) begin
                            count_tick <= '0;
                            if (count_bit == BIT_W'(NBITS - 1)) begin
                                Tx    <= 1'b1;
                                state <= STOPBIT;
                            end else begin
                                shift     <= shift >> 1;
                                Tx        <= shift[1];
                                count_bit <= count_bit + BIT_W'(1);
                            end
                        end else begin
                            count_tick <= count_tick + TICK_W'(1);
                        end
                    end
                    STOPBIT: begin
                        if (bit_last_c) begin
                            done       <= 1'b1;
                            count_tick <= '0;
                            if (!empty) begin
                                shift <= head_c;
                                Tx    <= 1'b0;
                                state <= STARTBIT;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            count_tick <= count_tick + TICK_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 2 clocks/tick, 16 ticks/bit: 32 clocks per bit, 320 per frame.
module tb_uart_tx;

    localparam int unsigned CPT = 2;
    localparam int unsigned TPB = 16;

    logic       clk50   = 1'b0;
    logic       nreset  = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic       Tx;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    uart_tx #(
        .CLKS_PER_TICK(CPT),
        .TICKS_PER_BIT(TPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk50  (clk50),
        .nreset (nreset),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .empty  (empty),
        .Tx     (Tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk50 = ~clk50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    // Line image of a frame, index 0 = start bit.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic wait_fall(input int max_steps, output int lat);
        lat = -1;
        for (int i = 1; i <= max_steps; i++) begin
            step();
            if (Tx === 1'b0) begin
                lat = i;
                break;
            end
        end
    endtask

    // Records the line from the cycle Tx fell (offset 0) through offset 319, ends at offset 320.
    task automatic capture_frame(output logic [9:0] first, output logic [9:0] last,
                                 output int early_done, output int busy_low,
                                 output int full_seen, output logic done_end);
        first = '0; last = '0; early_done = 0; busy_low = 0; full_seen = 0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 32; k++) begin
                if (k == 0)  first[i] = Tx;
                if (k == 31) last[i]  = Tx;
                if ((i != 0 || k != 0) && done === 1'b1) early_done++;
                if (busy !== 1'b1) busy_low++;
                if (full === 1'b1) full_seen++;
                step();
            end
        end
        done_end = done;
    endtask

    // Mid-bit receiver; elapsed < 0 means wait for the start edge first. Returns at mid stop bit.
    task automatic rx_byte(input int elapsed, output logic [7:0] b, output logic ok);
        int lat;
        int e;
        b  = 8'h00;
        ok = 1'b1;
        e  = elapsed;
        if (e < 0) begin
            wait_fall(2000, lat);
            if (lat < 0) begin
                ok = 1'b0;
                return;
            end
            e = 0;
        end
        repeat (16 - e) step();
        if (Tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (32) step();
            b[i] = Tx;
        end
        repeat (32) step();
        if (Tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        int done_cnt = 0, tx_low = 0, busy_hi = 0, bad_flags = 0;
        nreset = 1'b0;
        repeat (5) step();
        checks++; if (Tx !== 1'b1)    begin failures++; $display("FAIL reset_tx got=%b exp=1", Tx); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (full !== 1'b0)  begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        nreset = 1'b1;
        repeat (1000) begin
            step();
            if (done === 1'b1) done_cnt++;
            if (Tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
            if (empty !== 1'b1 || full !== 1'b0) bad_flags++;
        end
        checks++; if (done_cnt != 0)  begin failures++; $display("FAIL idle_done got=%0d pulses exp=0", done_cnt); end
        checks++; if (tx_low != 0)    begin failures++; $display("FAIL idle_tx got=%0d non-high cycles exp=0", tx_low); end
        checks++; if (busy_hi != 0)   begin failures++; $display("FAIL idle_busy got=%0d busy cycles exp=0", busy_hi); end
        checks++; if (bad_flags != 0) begin failures++; $display("FAIL idle_flags got=%0d bad cycles exp=0", bad_flags); end
    endtask

    task automatic test_single();
        int lat, ed, bl, fs, tx_low = 0;
        logic [9:0] f0, f1;
        logic de;
        wr_data = 8'hA5; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        wait_fall(4, lat);
        checks++; if (lat < 1 || lat > 3) begin failures++; $display("FAIL single_latency got=%0d exp=1..3", lat); end
        if (lat < 0) return;
        capture_frame(f0, f1, ed, bl, fs, de);
        checks++; if (f0 !== frame_of(8'hA5)) begin failures++; $display("FAIL single_bits_start got=%b exp=%b", f0, frame_of(8'hA5)); end
        checks++; if (f1 !== frame_of(8'hA5)) begin failures++; $display("FAIL single_bits_end got=%b exp=%b", f1, frame_of(8'hA5)); end
        checks++; if (ed != 0)   begin failures++; $display("FAIL single_early_done got=%0d exp=0", ed); end
        checks++; if (bl != 0)   begin failures++; $display("FAIL single_busy got=%0d low cycles exp=0", bl); end
        checks++; if (de !== 1'b1) begin failures++; $display("FAIL single_done_320 got=%b exp=1", de); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_drop got=%b exp=0", busy); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_width got=%b exp=0", done); end
        repeat (100) begin
            if (Tx !== 1'b1) tx_low++;
            step();
        end
        checks++; if (tx_low != 0) begin failures++; $display("FAIL single_tx_after got=%0d low cycles exp=0", tx_low); end
    endtask

    task automatic test_back_to_back();
        int lat, ed, bl, fs, bl_total;
        logic [9:0] f0, f1;
        logic de;
        wr_data = 8'h00; wr_en = 1'b1;
        step();
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        if (Tx === 1'b0) lat = 0; else wait_fall(4, lat);
        checks++; if (lat < 0) begin failures++; $display("FAIL b2b_start got=no start exp=start within 4"); return; end
        capture_frame(f0, f1, ed, bl, fs, de);
        bl_total = bl;
        checks++; if (f0 !== frame_of(8'h00)) begin failures++; $display("FAIL b2b_frame1 got=%b exp=%b", f0, frame_of(8'h00)); end
        checks++; if (de !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", de); end
        checks++; if (ed != 0) begin failures++; $display("FAIL b2b_early_done1 got=%0d exp=0", ed); end
        capture_frame(f0, f1, ed, bl, fs, de);
        bl_total += bl;
        checks++; if (f0 !== frame_of(8'hFF)) begin failures++; $display("FAIL b2b_frame2 got=%b exp=%b", f0, frame_of(8'hFF)); end
        checks++; if (f1 !== frame_of(8'hFF)) begin failures++; $display("FAIL b2b_frame2_end got=%b exp=%b", f1, frame_of(8'hFF)); end
        checks++; if (de !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", de); end
        checks++; if (ed != 0) begin failures++; $display("FAIL b2b_early_done2 got=%0d exp=0", ed); end
        checks++; if (bl_total != 0) begin failures++; $display("FAIL b2b_busy got=%0d low cycles exp=0", bl_total); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_drop got=%b exp=0", busy); end
        repeat (40) step();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        logic [7:0] got;
        logic ok;
        int model_count = 0, fall_step = -1, elapsed, frames = 0, extra_low = 0;
        bit acc, pop_now;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(i + 1); wr_en = 1'b1;
            acc = (model_count < 4);
            step();
            if (acc) exp_q.push_back(8'(i + 1));
            pop_now = (fall_step < 0) && (Tx === 1'b0);
            if (pop_now) fall_step = i;
            model_count = model_count + int'(acc) - int'(pop_now);
            checks++; if (full !== (model_count == 4)) begin failures++; $display("FAIL ovf_full_%0d got=%b exp=%b", i, full, model_count == 4); end
        end
        wr_en = 1'b0;
        checks++; if (fall_step < 0) begin failures++; $display("FAIL ovf_first_pop got=none exp=during writes"); end
        elapsed = (fall_step < 0) ? -1 : 5 - fall_step;
        for (int f = 0; f < exp_q.size(); f++) begin
            rx_byte(f == 0 ? elapsed : -1, got, ok);
            if (ok) frames++;
            checks++; if (!ok || got !== exp_q[f]) begin failures++; $display("FAIL ovf_byte_%0d got=%h ok=%b exp=%h", f, got, ok, exp_q[f]); end
        end
        repeat (400) begin
            step();
            if (Tx !== 1'b1) extra_low++;
        end
        checks++; if (frames != 5) begin failures++; $display("FAIL ovf_frames got=%0d exp=5", frames); end
        checks++; if (extra_low != 0) begin failures++; $display("FAIL ovf_extra_frame got=%0d low cycles exp=0", extra_low); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_midframe();
        int lat, tx_low = 0, busy_hi = 0;
        wr_data = 8'h3C; wr_en = 1'b1;
        step();
        wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        if (Tx === 1'b0) lat = 0; else wait_fall(4, lat);
        checks++; if (lat < 0) begin failures++; $display("FAIL rst_start got=no start exp=start within 4"); return; end
        repeat (5 * 32 + 10) step();
        checks++; if (Tx !== 1'b1 || busy !== 1'b1 || empty !== 1'b0) begin
            failures++; $display("FAIL rst_pre got tx=%b busy=%b empty=%b exp tx=1 busy=1 empty=0", Tx, busy, empty);
        end
        nreset = 1'b0;
        #1;
        checks++; if (Tx !== 1'b1)    begin failures++; $display("FAIL rst_async_tx got=%b exp=1", Tx); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_async_empty got=%b exp=1", empty); end
        repeat (3) step();
        nreset = 1'b1;
        repeat (700) begin
            step();
            if (Tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
        end
        checks++; if (tx_low != 0 || busy_hi != 0) begin
            failures++; $display("FAIL rst_after got tx_low=%0d busy_hi=%0d exp=0,0", tx_low, busy_hi);
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_after_empty got=%b exp=1", empty); end
    endtask

    task automatic test_simultaneous();
        int lat, ed, bl, fs;
        logic [9:0] f0, f1;
        logic de;
        wr_data = 8'h96; wr_en = 1'b1;
        step();
        wr_data = 8'h4B;
        step();
        wr_en = 1'b0;
        if (Tx === 1'b0) lat = 0; else wait_fall(4, lat);
        checks++; if (lat < 0) begin failures++; $display("FAIL sim_start got=no start exp=start within 4"); return; end
        repeat (319) step();
        checks++; if (empty !== 1'b0 || full !== 1'b0) begin
            failures++; $display("FAIL sim_pre got empty=%b full=%b exp empty=0 full=0", empty, full);
        end
        wr_data = 8'hE1; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        wr_data = 8'h00;
        checks++; if (done !== 1'b1 || Tx !== 1'b0) begin
            failures++; $display("FAIL sim_pop got done=%b tx=%b exp done=1 tx=0", done, Tx);
        end
        checks++; if (empty !== 1'b0 || full !== 1'b0) begin
            failures++; $display("FAIL sim_count got empty=%b full=%b exp empty=0 full=0", empty, full);
        end
        capture_frame(f0, f1, ed, bl, fs, de);
        checks++; if (f0 !== frame_of(8'h4B) || de !== 1'b1 || fs != 0) begin
            failures++; $display("FAIL sim_frame_b got=%b done=%b full_cycles=%0d exp=%b done=1 full_cycles=0", f0, de, fs, frame_of(8'h4B));
        end
        capture_frame(f0, f1, ed, bl, fs, de);
        checks++; if (f0 !== frame_of(8'hE1) || de !== 1'b1 || fs != 0) begin
            failures++; $display("FAIL sim_frame_c got=%b done=%b full_cycles=%0d exp=%b done=1 full_cycles=0", f0, de, fs, frame_of(8'hE1));
        end
        checks++; if (busy !== 1'b0 || empty !== 1'b1) begin
            failures++; $display("FAIL sim_end got busy=%b empty=%b exp busy=0 empty=1", busy, empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
